// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, selects sequential/branch/jump successor,
// and registers the fetched word into the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid
);

  typedef enum logic {
    BUBBLE = 1'b0,
    VALID  = 1'b1
  } slot_e;

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  slot_e       slot_q, slot_d;

  logic [31:0] pc_plus4;
  logic [31:0] jump_target;

  assign pc_plus4    = pc_q + 32'd4;
  assign jump_target = {pc4_q[31:28], instr_q[25:0], 2'b00};

  // Branch is the oldest redirect, so it outranks jump; both outrank stall.
  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path leaves it unassigned (no latches).
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    slot_d  = slot_q;
    if (branch_taken) begin
      pc_d    = {branch_target[31:2], 2'b00};
      instr_d = '0;
      pc4_d   = '0;
      slot_d  = BUBBLE;
    end else if (jump && (slot_q == VALID)) begin
      pc_d    = jump_target;
      instr_d = '0;
      pc4_d   = '0;
      slot_d  = BUBBLE;
    end else if (!stall) begin
      pc_d    = pc_plus4;
      instr_d = instr;
      pc4_d   = pc_plus4;
      slot_d  = VALID;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pc4_q   <= '0;
      slot_q  <= BUBBLE;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      slot_q  <= slot_d;
    end
  end

  assign pc             = pc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc_plus4 = pc4_q;
  assign if_id_valid    = (slot_q == VALID);

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage for the pipelined MIPS core. Owns the program counter, drives the word-addressed instruction memory with `pc`, selects the next PC (sequential, branch, or jump), and registers the fetched word into the IF/ID pipeline register. It sits directly upstream of the instruction memory and directly upstream of the decode stage.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `instr`  in  32  word returned by the instruction memory for the current `pc`; combinational, same cycle.
- `stall`  in  1  hazard unit: hold PC and IF/ID.
- `branch_taken`  in  1  EX stage: a branch resolved taken this cycle.
- `branch_target`  in  32  EX stage: byte address of the branch target.
- `jump`  in  1  ID stage: the instruction in IF/ID is `j`.
- `pc`  out  32  current fetch address, registered; drives instruction memory.
- `if_id_instr`  out  32  registered instruction for decode.
- `if_id_pc_plus4`  out  32  registered `pc + 4` of that instruction.
- `if_id_valid`  out  1  IF/ID holds a real instruction (0 = bubble).

## Operation
- `pc_plus4 = pc + 4`, 32-bit modulo add; 32'hFFFF_FFFC wraps to 0. No range check against memory depth.
- `jump_target = {if_id_pc_plus4[31:28], if_id_instr[25:0], 2'b00}`, computed internally from the IF/ID contents.
- Next-state selection, highest priority first:
  - `branch_taken`: `pc <= branch_target`; IF/ID loaded with bubble (`if_id_instr = 0`, `if_id_pc_plus4 = 0`, `if_id_valid = 0`). Overrides `jump` and `stall`, since the branch is older.
  - `jump` (with `if_id_valid = 1`): `pc <= jump_target`; IF/ID loaded with bubble. Overrides `stall`. `jump` while `if_id_valid = 0` is ignored.
  - `stall`: `pc`, `if_id_instr`, `if_id_pc_plus4`, `if_id_valid` all hold.
  - Otherwise: `pc <= pc_plus4`; `if_id_instr <= instr`; `if_id_pc_plus4 <= pc_plus4`; `if_id_valid <= 1`.
- `branch_target` low two bits are forced to 00 when loaded into `pc`.
- No internal FSM beyond the PC and IF/ID registers. The valid bit acts as a two-state marker: BUBBLE and VALID.

## Timing
- Reset, asynchronous assert, while `rst = 0`:
  - `pc = RESET_PC`
  - `if_id_instr = 0`
  - `if_id_pc_plus4 = 0`
  - `if_id_valid = 0`
- First rising edge after `rst` goes high captures the word at `RESET_PC` into IF/ID (`if_id_valid = 1`).
- Fetch latency is 1 cycle: the word addressed by `pc` in cycle N appears on `if_id_instr` after edge N.
- Redirect penalties:
  - Taken branch: 1 bubble from this block, which flushes IF/ID. Flushing later stages is the hazard unit's job.
  - Jump: 1 bubble.
- `stall` held for K cycles freezes outputs for exactly K cycles; sequencing resumes on the first edge with `stall = 0`.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Reset and sequential fetch:
  - Stimulus: hold `rst = 0` for 3 cycles, then release; memory returns `instr = pc` value.
  - Response: `pc`, IF/ID all 0 during reset. After release, `pc` goes 0, 4, 8, C; `if_id_instr` goes 0, 4, 8 one cycle behind; `if_id_pc_plus4` goes 4, 8, C; `if_id_valid` rises after the first edge.
- Stall:
  - Stimulus: at `pc = 8`, assert `stall` for 2 cycles.
  - Response: `pc` stays 8 and IF/ID stays unchanged for 2 edges; the next edge gives `pc = C` and `if_id_instr` = word at 8.
- Taken branch:
  - Stimulus: at `pc = 10`, pulse `branch_taken` with `branch_target = 32'h40`.
  - Response: next cycle `pc = 40` and `if_id_valid = 0`; one cycle later `if_id_instr` = word at 40, valid 1.
- Jump:
  - Stimulus: IF/ID holds 32'h08000004 (j 0x10) with `if_id_pc_plus4 = 20`; assert `jump`.
  - Response: `pc = 32'h10`, IF/ID bubble.
  - Also: `jump` with `if_id_valid = 0` leaves `pc` sequential.
- Simultaneous events:
  - Stimulus: `branch_taken` (target 0x80), `jump`, and `stall` all high in the same cycle.
  - Response: `pc = 80`, IF/ID bubble. Stimulus: `jump` together with `stall` → jump taken, stall ignored.
- Reset mid-operation and wrap-around:
  - Stimulus: drop `rst` asynchronously mid-cycle at `pc = 24`.
  - Response: `pc` immediately `RESET_PC`, IF/ID cleared.
  - Stimulus: `branch_target = FFFF_FFFC`, then run sequentially.
  - Response: `pc` wraps to 0.
